// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg: shared widths, constants and types for the write-back queue
package wb_queue_pkg;
    localparam int RegBus = 32;
    localparam int RegAddrBus = 5;
    localparam int WbqDepth = 4;
    localparam int PtrW = $clog2(WbqDepth);
    localparam logic WriteEnable = 1'b1;
    localparam logic [RegBus-1:0] ZeroWord = '0;
    typedef logic [RegBus-1:0] word_t;
    typedef logic [RegAddrBus-1:0] reg_addr_t;
    typedef logic [PtrW-1:0] ptr_t;
endpackage

// File: rtl/wb_queue_lookup.sv
// wbq_lookup: youngest-match forwarding search over pending and same-cycle write-backs
module wbq_lookup
    import wb_queue_pkg::*;
(
    input  reg_addr_t                  raddr,
    input  logic [WbqDepth-1:0]        valid,
    input  reg_addr_t [WbqDepth-1:0]   addr,
    input  word_t [WbqDepth-1:0]       data,
    input  ptr_t                       head,
    input  logic                       push_a,
    input  reg_addr_t                  a_addr,
    input  word_t                      a_data,
    input  logic                       push_b,
    input  reg_addr_t                  b_addr,
    input  word_t                      b_data,
    output logic                       hit,
    output word_t                      fdata
);
    // walk oldest to youngest so later matches win, then A and B pushes, B last as youngest
    always_comb begin
        hit = 1'b0;
        fdata = ZeroWord;
        for (int i = 0; i < WbqDepth; i++) begin
            if (valid[head + ptr_t'(i)] && addr[head + ptr_t'(i)] == raddr) begin
                hit = WriteEnable;
                fdata = data[head + ptr_t'(i)];
            end
        end
        if (push_a && a_addr == raddr) begin
            hit = WriteEnable;
            fdata = a_data;
        end
        if (push_b && b_addr == raddr) begin
            hit = WriteEnable;
            fdata = b_data;
        end
        if (raddr == '0) begin
            hit = 1'b0;
            fdata = ZeroWord;
        end
    end
endmodule

// File: rtl/wb_queue.sv
// wb_queue: 4-entry write-back FIFO merging two result ports into one register-file write port with forwarding
module wb_queue
    import wb_queue_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      a_we,
    input  reg_addr_t a_waddr,
    input  word_t     a_wdata,
    input  logic      b_we,
    input  reg_addr_t b_waddr,
    input  word_t     b_wdata,
    output logic      in_ready,
    output logic      we,
    output reg_addr_t waddr,
    output word_t     wdata,
    input  reg_addr_t raddr1,
    input  reg_addr_t raddr2,
    output logic      hit1,
    output logic      hit2,
    output word_t     fdata1,
    output word_t     fdata2
);
    logic [WbqDepth-1:0] valid_q, valid_d;
    reg_addr_t [WbqDepth-1:0] addr_q;
    word_t [WbqDepth-1:0] data_q;
    ptr_t head_q, head_d, tail_q, tail_d, tail_b;
    logic [2:0] count_q, count_d;
    logic push_a, push_b;

    // pushes are suppressed while reset is held so nothing leaks to the forwarding outputs
    assign in_ready = count_q <= 3'd2;
    assign push_a = a_we && a_waddr != '0 && in_ready && !rst;
    assign push_b = b_we && b_waddr != '0 && in_ready && !rst;
    assign tail_b = tail_q + ptr_t'(push_a);
    assign we = count_q != 3'd0;
    assign waddr = we ? addr_q[head_q] : '0;
    assign wdata = we ? data_q[head_q] : ZeroWord;

    // next-state: pop the head whenever writing, A enqueues before B
    always_comb begin
        valid_d = valid_q;
        if (we) valid_d[head_q] = 1'b0;
        if (push_a) valid_d[tail_q] = 1'b1;
        if (push_b) valid_d[tail_b] = 1'b1;
        head_d = head_q + ptr_t'(we);
        tail_d = tail_b + ptr_t'(push_b);
        count_d = count_q + {2'b0, push_a} + {2'b0, push_b} - {2'b0, we};
    end

    // control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
    end

    // payload storage is not reset; valid bits and count gate every use of it
    always_ff @(posedge clk) begin
        if (push_a) begin
            addr_q[tail_q] <= a_waddr;
            data_q[tail_q] <= a_wdata;
        end
        if (push_b) begin
            addr_q[tail_b] <= b_waddr;
            data_q[tail_b] <= b_wdata;
        end
    end

    wbq_lookup u_lookup1 (
        .raddr(raddr1), .valid(valid_q), .addr(addr_q), .data(data_q), .head(head_q),
        .push_a(push_a), .a_addr(a_waddr), .a_data(a_wdata),
        .push_b(push_b), .b_addr(b_waddr), .b_data(b_wdata),
        .hit(hit1), .fdata(fdata1)
    );

    wbq_lookup u_lookup2 (
        .raddr(raddr2), .valid(valid_q), .addr(addr_q), .data(data_q), .head(head_q),
        .push_a(push_a), .a_addr(a_waddr), .a_data(a_wdata),
        .push_b(push_b), .b_addr(b_waddr), .b_data(b_wdata),
        .hit(hit2), .fdata(fdata2)
    );
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: randomized scoreboard bench for wb_queue with a queue-based reference model
module tb_wb_queue;
    logic clk = 1'b0;
    logic rst;
    logic a_we, b_we;
    logic [4:0] a_waddr, b_waddr, raddr1, raddr2, waddr;
    logic [31:0] a_wdata, b_wdata, wdata, fdata1, fdata2;
    logic in_ready, we, hit1, hit2;

    int n_cmp = 0;
    int n_fail = 0;
    logic [36:0] pend[$];
    logic [36:0] exp_q[$];

    wb_queue dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_we(b_we), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .hit1(hit1), .hit2(hit2), .fdata1(fdata1), .fdata2(fdata2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // newest pending value for r: B push, then A push, then queue from youngest to oldest
    task automatic look(input logic [4:0] r, input logic pa, input logic [4:0] aa, input logic [31:0] ad,
                        input logic pb, input logic [4:0] ba, input logic [31:0] bd,
                        output logic h, output logic [31:0] f);
        h = 1'b0;
        f = 32'h0;
        if (r == 5'd0) return;
        if (pb && ba == r) begin h = 1'b1; f = bd; return; end
        if (pa && aa == r) begin h = 1'b1; f = ad; return; end
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i][36:32] == r) begin h = 1'b1; f = pend[i][31:0]; return; end
        end
    endtask

    // one clock of stimulus: drive, check combinational outputs against the model, advance the model
    task automatic cycle(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bw, input logic [4:0] ba, input logic [31:0] bd,
                         input logic [4:0] r1, input logic [4:0] r2);
        logic rdy, pa, pb, eh;
        logic [31:0] ef;
        @(posedge clk);
        #1;
        a_we = aw; a_waddr = aa; a_wdata = ad;
        b_we = bw; b_waddr = ba; b_wdata = bd;
        raddr1 = r1; raddr2 = r2;
        rdy = pend.size() <= 2;
        pa = aw && aa != 5'd0 && rdy;
        pb = bw && ba != 5'd0 && rdy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("we", 32'(we), 32'(pend.size() > 0));
        look(r1, pa, aa, ad, pb, ba, bd, eh, ef);
        chk("hit1", 32'(hit1), 32'(eh));
        chk("fdata1", fdata1, ef);
        look(r2, pa, aa, ad, pb, ba, bd, eh, ef);
        chk("hit2", 32'(hit2), 32'(eh));
        chk("fdata2", fdata2, ef);
        if (pend.size() > 0) void'(pend.pop_front());
        if (pa) begin pend.push_back({aa, ad}); exp_q.push_back({aa, ad}); end
        if (pb) begin pend.push_back({ba, bd}); exp_q.push_back({ba, bd}); end
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, r1, r2);
    endtask

    // write monitor: every register-file write must be the oldest accepted push
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write", 32'(waddr), 32'h0);
                    chk("spurious_we", 32'(we), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("waddr", 32'(waddr), 32'(e[36:32]));
                    chk("wdata", wdata, e[31:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h55;
        b_we = 1'b0; b_waddr = 5'd0; b_wdata = 32'h0;
        raddr1 = 5'd3; raddr2 = 5'd0;
        #12;
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_waddr", 32'(waddr), 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_hit1", 32'(hit1), 32'h0);
        chk("rst_fdata1", fdata1, 32'h0);
        chk("rst_hit2", 32'(hit2), 32'h0);
        a_we = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        cycle(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        idle(5'd3, 5'd0);
        chk("first_we", 32'(we), 32'h1);
        chk("first_waddr", 32'(waddr), 32'h3);
        chk("first_wdata", wdata, 32'h11);
        idle(5'd3, 5'd0);
        chk("first_drained", 32'(we), 32'h0);

        cycle(1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB, 5'd5, 5'd0);
        chk("dual_hit1", 32'(hit1), 32'h1);
        chk("dual_fdata1_b", fdata1, 32'hB);
        idle(5'd5, 5'd0);
        chk("dual_first_wdata", wdata, 32'hA);
        idle(5'd5, 5'd0);
        chk("dual_second_wdata", wdata, 32'hB);
        idle(5'd0, 5'd0);

        cycle(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102, 5'd1, 5'd2);
        cycle(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104, 5'd2, 5'd4);
        cycle(1'b1, 5'd6, 32'h106, 1'b1, 5'd7, 32'h107, 5'd6, 5'd7);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        chk("full_drop_hit1", 32'(hit1), 32'h0);
        repeat (4) idle(5'd6, 5'd4);

        cycle(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        chk("zero_hit2", 32'(hit2), 32'h0);
        chk("zero_fdata2", fdata2, 32'h0);
        idle(5'd0, 5'd0);
        chk("zero_no_write", 32'(we), 32'h0);

        cycle(1'b1, 5'd8, 32'h208, 1'b1, 5'd9, 32'h209, 5'd8, 5'd9);
        cycle(1'b1, 5'd10, 32'h20A, 1'b1, 5'd11, 32'h20B, 5'd10, 5'd11);
        @(posedge clk);
        #1 rst = 1'b1;
        a_we = 1'b0; b_we = 1'b0; raddr1 = 5'd10; raddr2 = 5'd11;
        #1;
        chk("midrst_we", 32'(we), 32'h0);
        chk("midrst_hit1", 32'(hit1), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        pend.delete();
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(5'd10, 5'd11);
        idle(5'd9, 5'd8);

        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        repeat (5) idle(5'd0, 5'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
